// File: rtl/rf_write_arbiter.sv
// Round-robin arbitrated write port into a small register bank with a combinational read port.
// Define RF_WR_LOCK_EN to enable burst locking; the default build ignores the lock input.
module rf_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   waddr,
    input  logic [NREQ*DW-1:0]   wdata,
    input  logic [AW-1:0]        raddr,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      ack,
    output logic [1:0]           gnt_id,
    output logic                 busy
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int          IW    = 2;

    logic [DW-1:0]   bank_q [DEPTH];
    logic [DW-1:0]   bank_d [DEPTH];
    logic [NREQ-1:0] ack_q, ack_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   waddr_a [NREQ];
    logic [DW-1:0]   wdata_a [NREQ];
    logic [NREQ-1:0] eligible;
    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   idx;

`ifdef RF_WR_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;
    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            lock_hold;
`else
    logic            unused_lock;
    assign unused_lock = ^lock;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            waddr_a[i] = waddr[i*AW +: AW];
            wdata_a[i] = wdata[i*DW +: DW];
        end
    end

    always_comb begin
        eligible = req & ~ack_q;
        win_vld  = 1'b0;
        win_idx  = '0;
        idx      = '0;
        ack_d    = '0;
        busy_d   = 1'b0;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        bank_d   = bank_q;
`ifdef RF_WR_LOCK_EN
        state_d   = state_q;
        owner_d   = owner_q;
        lock_hold = 1'b0;
        // A burst that is ending hands over via ordinary arbitration, owner excluded.
        if (state_q == LOCKED) begin
            if (req[owner_q] && lock[owner_q]) begin
                lock_hold = 1'b1;
                win_vld   = 1'b1;
                win_idx   = owner_q;
            end else begin
                eligible[owner_q] = 1'b0;
                state_d           = ARB;
            end
        end
        if (!lock_hold) begin
`endif
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = rr_q + IW'(k);
                if (!win_vld && eligible[idx]) begin
                    win_vld = 1'b1;
                    win_idx = idx;
                end
            end
`ifdef RF_WR_LOCK_EN
            if (win_vld && lock[win_idx]) begin
                state_d = LOCKED;
                owner_d = win_idx;
            end
        end
`endif
        if (win_vld) begin
            bank_d[waddr_a[win_idx]] = wdata_a[win_idx];
            ack_d[win_idx]           = 1'b1;
            gnt_d                    = win_idx;
            rr_d                     = win_idx + 1'b1;
            busy_d                   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            ack_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
`ifdef RF_WR_LOCK_EN
            state_q <= ARB;
            owner_q <= '0;
`endif
        end else begin
            bank_q  <= bank_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
`ifdef RF_WR_LOCK_EN
            state_q <= state_d;
            owner_q <= owner_d;
`endif
        end
    end

    assign rdata  = bank_q[raddr];
    assign ack    = ack_q;
    assign gnt_id = gnt_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: vector table plus hand sequences for reset,
// no-bypass reads and (with RF_WR_LOCK_EN) burst locking.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [7:0]  rdata;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(.NREQ(4), .DW(8), .AW(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (raddr),
        .rdata  (rdata),
        .ack    (ack),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [3:0]  ack;
        logic [1:0]  gnt;
        logic        busy;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] a, input logic [1:0] g, input logic b);
        chk({nm, ".ack"}, 32'(ack), 32'(a));
        chk({nm, ".gnt_id"}, 32'(gnt_id), 32'(g));
        chk({nm, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic chk_rd(input string nm, input logic [2:0] a, input logic [7:0] exp);
        raddr = a;
        #1;
        chk(nm, 32'(rdata), 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;

        //            rst  req      waddr {a3,a2,a1,a0}          wdata {d3,d2,d1,d0}               raddr  ack      gnt  busy rdata
        vt[0]  = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd5}, {8'h00,8'h00,8'h00,8'hA5}, 3'd5, 4'b0001, 2'd0, 1'b1, 8'hA5};
        vt[1]  = '{1'b0, 4'b0000, {3'd0,3'd0,3'd0,3'd5}, {8'h00,8'h00,8'h00,8'hA5}, 3'd5, 4'b0000, 2'd0, 1'b0, 8'hA5};
        vt[2]  = '{1'b1, 4'b0000, {3'd0,3'd0,3'd0,3'd5}, {8'h00,8'h00,8'h00,8'hA5}, 3'd5, 4'b0000, 2'd0, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, {8'h13,8'h12,8'h11,8'h10}, 3'd0, 4'b0001, 2'd0, 1'b1, 8'h10};
        vt[4]  = '{1'b0, 4'b1110, {3'd3,3'd2,3'd1,3'd0}, {8'h13,8'h12,8'h11,8'h10}, 3'd1, 4'b0010, 2'd1, 1'b1, 8'h11};
        vt[5]  = '{1'b0, 4'b1100, {3'd3,3'd2,3'd1,3'd0}, {8'h13,8'h12,8'h11,8'h10}, 3'd2, 4'b0100, 2'd2, 1'b1, 8'h12};
        vt[6]  = '{1'b0, 4'b1000, {3'd3,3'd2,3'd1,3'd0}, {8'h13,8'h12,8'h11,8'h10}, 3'd3, 4'b1000, 2'd3, 1'b1, 8'h13};
        vt[7]  = '{1'b0, 4'b0000, {3'd3,3'd2,3'd1,3'd0}, {8'h13,8'h12,8'h11,8'h10}, 3'd0, 4'b0000, 2'd3, 1'b0, 8'h10};
        vt[8]  = '{1'b0, 4'b0010, {3'd0,3'd0,3'd6,3'd0}, {8'h00,8'h00,8'h61,8'h00}, 3'd6, 4'b0010, 2'd1, 1'b1, 8'h61};
        vt[9]  = '{1'b0, 4'b0000, {3'd0,3'd0,3'd6,3'd0}, {8'h00,8'h00,8'h61,8'h00}, 3'd6, 4'b0000, 2'd1, 1'b0, 8'h61};
        vt[10] = '{1'b0, 4'b0011, {3'd0,3'd0,3'd4,3'd7}, {8'h00,8'h00,8'h41,8'h70}, 3'd7, 4'b0001, 2'd0, 1'b1, 8'h70};
        vt[11] = '{1'b0, 4'b0010, {3'd0,3'd0,3'd4,3'd7}, {8'h00,8'h00,8'h41,8'h70}, 3'd4, 4'b0010, 2'd1, 1'b1, 8'h41};
        vt[12] = '{1'b0, 4'b0000, {3'd0,3'd0,3'd4,3'd7}, {8'h00,8'h00,8'h41,8'h70}, 3'd4, 4'b0000, 2'd1, 1'b0, 8'h41};
        vt[13] = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd2}, {8'h00,8'h00,8'h00,8'h22}, 3'd2, 4'b0001, 2'd0, 1'b1, 8'h22};
        vt[14] = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd2}, {8'h00,8'h00,8'h00,8'h22}, 3'd2, 4'b0000, 2'd0, 1'b0, 8'h22};
        vt[15] = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd2}, {8'h00,8'h00,8'h00,8'h33}, 3'd2, 4'b0001, 2'd0, 1'b1, 8'h33};
        vt[16] = '{1'b0, 4'b0000, {3'd0,3'd0,3'd0,3'd2}, {8'h00,8'h00,8'h00,8'h33}, 3'd2, 4'b0000, 2'd0, 1'b0, 8'h33};

        // Reset state and full read sweep
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            chk_rd($sformatf("reset_rd%0d", a), 3'(a), 8'h00);
        end

        for (int i = 0; i < 17; i++) begin
            reset = vt[i].rst;
            req   = vt[i].req;
            lock  = '0;
            waddr = vt[i].waddr;
            wdata = vt[i].wdata;
            raddr = vt[i].raddr;
            step();
            chk_out($sformatf("vec%0d", i), vt[i].ack, vt[i].gnt, vt[i].busy);
            chk($sformatf("vec%0d.rdata", i), 32'(rdata), 32'(vt[i].rdata));
        end
        reset = 1'b0;

        // No bypass: old value visible until the write edge
        raddr = 3'd2;
        req   = 4'b0001;
        waddr = {3'd0, 3'd0, 3'd0, 3'd2};
        wdata = {8'h00, 8'h00, 8'h00, 8'h5A};
        #1;
        chk("nobypass_before", 32'(rdata), 32'h33);
        step();
        chk("nobypass_after", 32'(rdata), 32'h5A);
        chk_out("nobypass", 4'b0001, 2'd0, 1'b1);
        req = '0;
        step();

        // Burst lock (ignored in the default build)
        do_reset();
        req   = 4'b0101;
        lock  = 4'b0001;
        waddr = {3'd0, 3'd5, 3'd0, 3'd1};
        wdata = {8'h00, 8'hC5, 8'h00, 8'hB1};
        raddr = 3'd1;
        step();
        chk_out("lock_w1", 4'b0001, 2'd0, 1'b1);
        chk("lock_w1.rdata", 32'(rdata), 32'hB1);
        waddr = {3'd0, 3'd5, 3'd0, 3'd2};
        wdata = {8'h00, 8'hC5, 8'h00, 8'hB2};
`ifdef RF_WR_LOCK_EN
        step();
        chk_out("lock_w2", 4'b0001, 2'd0, 1'b1);
        chk_rd("lock_w2.rdata", 3'd2, 8'hB2);
        waddr = {3'd0, 3'd5, 3'd0, 3'd3};
        wdata = {8'h00, 8'hC5, 8'h00, 8'hB3};
        step();
        chk_out("lock_w3", 4'b0001, 2'd0, 1'b1);
        chk_rd("lock_w3.rdata", 3'd3, 8'hB3);
        chk_rd("lock_w3.rd5", 3'd5, 8'h00);
        lock = 4'b0000;
        req  = 4'b0100;
        step();
        chk_out("lock_release", 4'b0100, 2'd2, 1'b1);
        chk_rd("lock_release.rd5", 3'd5, 8'hC5);
`else
        step();
        chk_out("nolock_w2", 4'b0100, 2'd2, 1'b1);
        chk_rd("nolock_w2.rd5", 3'd5, 8'hC5);
        chk_rd("nolock_w2.rd2", 3'd2, 8'h00);
        step();
        chk_out("nolock_w3", 4'b0001, 2'd0, 1'b1);
        chk_rd("nolock_w3.rd2", 3'd2, 8'hB2);
`endif
        req  = '0;
        lock = '0;
        step();
        chk_out("lock_idle", 4'b0000, gnt_id === 2'd2 ? 2'd2 : 2'd0, 1'b0);

        // Reset in the middle of a (possibly locked) burst
        do_reset();
        req   = 4'b0101;
        lock  = 4'b0001;
        waddr = {3'd0, 3'd5, 3'd0, 3'd1};
        wdata = {8'h00, 8'hC5, 8'h00, 8'hD1};
        step();
        chk_out("mid_w1", 4'b0001, 2'd0, 1'b1);
        chk_rd("mid_w1.rd1", 3'd1, 8'hD1);
        reset = 1'b1;
        waddr = {3'd0, 3'd5, 3'd0, 3'd2};
        wdata = {8'h00, 8'hC5, 8'h00, 8'hD2};
        step();
        chk_out("mid_reset", 4'b0000, 2'd0, 1'b0);
        chk_rd("mid_reset.rd1", 3'd1, 8'h00);
        chk_rd("mid_reset.rd2", 3'd2, 8'h00);
        reset = 1'b0;
        lock  = 4'b0000;
        req   = 4'b0100;
        step();
        chk_out("post_reset_arb", 4'b0100, 2'd2, 1'b1);
        chk_rd("post_reset_arb.rd5", 3'd5, 8'hC5);
        req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
